load_store_unit: RTL and testbench

Memory-stage load/store sequencer between the execute stage and the byte-addressed data memory. Accepts one load or store per request handshake and computes the effective address (base + sign-extended 12-bit offset). Checks funct3 legality, alignment and range, then drives a single memory access. Returns load data, store completion, or a precise exception through a back-pressured response port.

---
 rtl/load_store_unit_if.sv | 57 +++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//
// Bundles the three port groups of the load/store unit:
//   req_*  : execute stage -> unit request channel (valid/ready)
//   mem_*  : unit -> data memory single-cycle access strobes
//   resp_*, exc_* : unit -> writeback response channel (valid/ready)
//
// Handshake rule for both req and resp channels: a transfer happens on a
// rising clk edge where valid and ready are both 1. The sender keeps valid
// and its payload stable until that edge; ready may change freely and has
// no effect while valid is low.
//
// Modports:
//   slave  : the load_store_unit side
//   master : the environment side (execute stage, memory, writeback)
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_is_load;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_wdata, req_rd, mem_read_data, resp_ready,
        output req_ready, mem_read, mem_write, mem_address, mem_funct3,
               mem_write_data, resp_valid, resp_is_load, resp_rd, resp_data,
               exc_valid, exc_cause, exc_addr
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset,
               req_wdata, req_rd, mem_read_data, resp_ready,
        input  req_ready, mem_read, mem_write, mem_address, mem_funct3,
               mem_write_data, resp_valid, resp_is_load, resp_rd, resp_data,
               exc_valid, exc_cause, exc_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory-stage sequencer: accepts one load/store, forms the effective
// address base + sext(offset), checks funct3 legality, alignment and range,
// performs at most one memory access, then returns data, store completion
// or a precise exception.
//
// Ports:
//   clk       : clock, all state changes on rising edge
//   rst       : synchronous active-high reset
//   bus       : load_store_unit_if.slave (req / mem / resp groups)
//   state_dbg : current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
//
// Both req and resp follow valid/ready: transfer on an edge where both are
// high; payload held stable by the sender until then.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    // latched request / response
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] ea_q;
    logic [31:0] resp_data_q;
    logic        exc_valid_q;
    logic [3:0]  exc_cause_q;
    logic [31:0] exc_addr_q;

    // request checks, evaluated on the live request in IDLE
    logic [31:0] ea;
    logic [32:0] size_m1;
    logic [32:0] last_byte;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_addr;
    logic        accept;

    assign ea = bus.req_base + {{20{bus.req_offset[11]}}, bus.req_offset};

    always_comb begin
        size_m1    = 33'd0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        trap_cause = 4'd0;
        trap_addr  = ea;

        case (bus.req_funct3[1:0])
            2'd1:    size_m1 = 33'd1;
            2'd2:    size_m1 = 33'd3;
            default: size_m1 = 33'd0;
        endcase

        if (bus.req_is_store)
            illegal = (bus.req_funct3 > 3'd2);
        else
            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                      (bus.req_funct3 == 3'd7);

        misaligned = ((bus.req_funct3[1:0] == 2'd1) && ea[0]) ||
                     ((bus.req_funct3[1:0] == 2'd2) && (ea[1:0] != 2'b00));

        // 33-bit sum so an access that wraps past 2^32 is also out of range
        last_byte    = {1'b0, ea} + size_m1;
        out_of_range = (last_byte >= 33'(MEM_BYTES));

        trap = illegal || misaligned || out_of_range;

        if (illegal) begin
            trap_cause = 4'd2;
            trap_addr  = 32'd0;
        end else if (misaligned) begin
            trap_cause = bus.req_is_store ? 4'd6 : 4'd4;
        end else if (out_of_range) begin
            trap_cause = bus.req_is_store ? 4'd7 : 4'd5;
        end
    end

    assign accept = (state == IDLE) && bus.req_valid;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state and outputs
    always_comb begin
        state_next         = state;
        bus.req_ready      = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = 32'd0;
        bus.mem_funct3     = 3'd0;
        bus.mem_write_data = 32'd0;
        bus.resp_valid     = 1'b0;
        bus.resp_is_load   = 1'b0;
        bus.resp_rd        = 5'd0;
        bus.resp_data      = 32'd0;
        bus.exc_valid      = 1'b0;
        bus.exc_cause      = 4'd0;
        bus.exc_addr       = 32'd0;

        case (state)
            IDLE: begin
                bus.req_ready = ~rst;
                if (bus.req_valid)
                    state_next = trap ? RESP : ISSUE;
            end
            ISSUE: begin
                // strobes gated with ~rst so a reset here cancels the access
                bus.mem_read       = ~is_store_q & ~rst;
                bus.mem_write      = is_store_q & ~rst;
                bus.mem_address    = ea_q;
                bus.mem_funct3     = funct3_q;
                bus.mem_write_data = is_store_q ? wdata_q : 32'd0;
                state_next         = RESP;
            end
            RESP: begin
                bus.resp_valid   = 1'b1;
                bus.resp_is_load = ~is_store_q & ~exc_valid_q;
                bus.resp_rd      = (~is_store_q & ~exc_valid_q) ? rd_q : 5'd0;
                bus.resp_data    = resp_data_q;
                bus.exc_valid    = exc_valid_q;
                bus.exc_cause    = exc_cause_q;
                bus.exc_addr     = exc_addr_q;
                if (bus.resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // request latch and load-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            ea_q        <= 32'd0;
            resp_data_q <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= 4'd0;
            exc_addr_q  <= 32'd0;
        end else if (accept) begin
            is_store_q  <= bus.req_is_store;
            funct3_q    <= bus.req_funct3;
            wdata_q     <= bus.req_wdata;
            rd_q        <= bus.req_rd;
            ea_q        <= ea;
            resp_data_q <= 32'd0;
            exc_valid_q <= trap;
            exc_cause_q <= trap_cause;
            exc_addr_q  <= trap ? trap_addr : 32'd0;
        end else if ((state == ISSUE) && !is_store_q) begin
            resp_data_q <= bus.mem_read_data;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Directed bench for load_store_unit with a byte-array memory model that
// returns width-adjusted read data combinationally and commits writes on
// the rising edge. Each test task drives its scenario and checks inline.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  state_dbg;
    int          checks;
    int          errors;
    int          cyc;
    int          write_count;
    int          accept_cyc;
    logic [7:0]  mem [0:4095];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(4096)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // memory model
    always_comb begin
        logic [11:0] a;
        a = bus.mem_address[11:0];
        case (bus.mem_funct3)
            3'd0:    bus.mem_read_data = {{24{mem[a][7]}}, mem[a]};
            3'd1:    bus.mem_read_data = {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
            3'd2:    bus.mem_read_data = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
            3'd4:    bus.mem_read_data = {24'd0, mem[a]};
            3'd5:    bus.mem_read_data = {16'd0, mem[a+12'd1], mem[a]};
            default: bus.mem_read_data = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            logic [11:0] a;
            a = bus.mem_address[11:0];
            write_count = write_count + 1;
            mem[a] = bus.mem_write_data[7:0];
            if (bus.mem_funct3 != 3'd0) mem[a+12'd1] = bus.mem_write_data[15:8];
            if (bus.mem_funct3 == 3'd2) begin
                mem[a+12'd2] = bus.mem_write_data[23:16];
                mem[a+12'd3] = bus.mem_write_data[31:24];
            end
        end
    end

    // driver: wait for req_ready (bounded), present request for one accept edge.
    // Returns #1 after the accepting edge (cycle N+1).
    task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                             input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
        int waited;
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL drive_req_timeout: req_ready=%b required 1", bus.req_ready);
        end
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        bus.req_valid    = 1'b1;
        @(posedge clk); #1;
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready_during: got %b need 0", bus.req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b need 1", bus.req_ready); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d need 0", state_dbg); end
        checks++; if ({bus.resp_valid, bus.exc_valid, bus.mem_read, bus.mem_write} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b need 0000", {bus.resp_valid, bus.exc_valid, bus.mem_read, bus.mem_write}); end
        checks++; if (bus.mem_address !== 32'd0 || bus.resp_data !== 32'd0) begin errors++; $display("FAIL rst_buses: addr %h data %h need 0", bus.mem_address, bus.resp_data); end
    endtask

    task automatic test_load_word();
        {mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]} = 32'hDEADBEEF;
        drive_req(1'b0, 3'd2, 32'h100, 12'h004, 32'd0, 5'd5);
        checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL lw_state_issue: got %0d need 1", state_dbg); end
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL lw_strobes: rd %b wr %b need 1 0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.mem_address !== 32'h104 || bus.mem_funct3 !== 3'd2) begin errors++; $display("FAIL lw_addr: addr %h f3 %0d need 104 2", bus.mem_address, bus.mem_funct3); end
        checks++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_issue_hs: rdy %b rv %b need 0 0", bus.req_ready, bus.resp_valid); end
        @(posedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_resp_data: rv %b data %h need 1 deadbeef", bus.resp_valid, bus.resp_data); end
        checks++; if (bus.resp_rd !== 5'd5 || bus.resp_is_load !== 1'b1 || bus.exc_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_meta: rd %0d ld %b exc %b need 5 1 0", bus.resp_rd, bus.resp_is_load, bus.exc_valid); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 32'd0) begin errors++; $display("FAIL lw_read_pulse: rd %b addr %h need 0 0", bus.mem_read, bus.mem_address); end
        @(posedge clk); #1;
        checks++; if (state_dbg !== 2'd0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_return_idle: state %0d rv %b need 0 0", state_dbg, bus.resp_valid); end
    endtask

    task automatic test_store_byte();
        mem[12'h00F] = 8'hAA;
        mem[12'h010] = 8'h33;
        drive_req(1'b1, 3'd0, 32'h10, 12'hFFF, 32'h12345678, 5'd0);
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL sb_strobes: wr %b rd %b need 1 0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_address !== 32'h0F || bus.mem_write_data !== 32'h12345678) begin errors++; $display("FAIL sb_addr_data: addr %h wd %h need 0f 12345678", bus.mem_address, bus.mem_write_data); end
        @(posedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_is_load !== 1'b0 || bus.resp_data !== 32'd0 || bus.exc_valid !== 1'b0) begin errors++; $display("FAIL sb_resp: rv %b ld %b data %h exc %b need 1 0 0 0", bus.resp_valid, bus.resp_is_load, bus.resp_data, bus.exc_valid); end
        checks++; if (mem[12'h00F] !== 8'h78 || mem[12'h010] !== 8'h33) begin errors++; $display("FAIL sb_mem: m0f %h m10 %h need 78 33", mem[12'h00F], mem[12'h010]); end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        int wc0;
        wc0 = write_count;
        drive_req(1'b1, 3'd2, 32'h100, 12'h002, 32'hCAFEF00D, 5'd0);
        checks++; if (state_dbg !== 2'd2 || bus.resp_valid !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("FAIL sw_mis_timing: state %0d rv %b wr %b need 2 1 0", state_dbg, bus.resp_valid, bus.mem_write); end
        checks++; if (bus.exc_valid !== 1'b1 || bus.exc_cause !== 4'd6 || bus.exc_addr !== 32'h102) begin errors++; $display("FAIL sw_mis_exc: exc %b cause %0d addr %h need 1 6 102", bus.exc_valid, bus.exc_cause, bus.exc_addr); end
        @(posedge clk); #1;
        checks++; if (write_count !== wc0) begin errors++; $display("FAIL sw_mis_no_write: writes %0d need %0d", write_count, wc0); end
        drive_req(1'b0, 3'd1, 32'h0, 12'h003, 32'd0, 5'd9);
        checks++; if (bus.exc_valid !== 1'b1 || bus.exc_cause !== 4'd4 || bus.exc_addr !== 32'h3) begin errors++; $display("FAIL lh_mis_exc: exc %b cause %0d addr %h need 1 4 3", bus.exc_valid, bus.exc_cause, bus.exc_addr); end
        checks++; if (bus.resp_is_load !== 1'b0 || bus.mem_read !== 1'b0 || bus.resp_data !== 32'd0) begin errors++; $display("FAIL lh_mis_quiet: ld %b rd %b data %h need 0 0 0", bus.resp_is_load, bus.mem_read, bus.resp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_range();
        {mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]} = 32'h11223344;
        mem[12'h000] = 8'h80;
        drive_req(1'b0, 3'd2, 32'hFF0, 12'h00C, 32'd0, 5'd1);
        checks++; if (state_dbg !== 2'd1 || bus.mem_address !== 32'hFFC) begin errors++; $display("FAIL lw_top_issue: state %0d addr %h need 1 ffc", state_dbg, bus.mem_address); end
        @(posedge clk); #1;
        checks++; if (bus.resp_data !== 32'h11223344 || bus.exc_valid !== 1'b0) begin errors++; $display("FAIL lw_top_data: data %h exc %b need 11223344 0", bus.resp_data, bus.exc_valid); end
        @(posedge clk); #1;
        drive_req(1'b0, 3'd2, 32'h1000, 12'h000, 32'd0, 5'd3);
        checks++; if (bus.exc_valid !== 1'b1 || bus.exc_cause !== 4'd5 || bus.exc_addr !== 32'h1000) begin errors++; $display("FAIL lw_oob: exc %b cause %0d addr %h need 1 5 1000", bus.exc_valid, bus.exc_cause, bus.exc_addr); end
        @(posedge clk); #1;
        drive_req(1'b0, 3'd0, 32'hFFFFFFFF, 12'h001, 32'd0, 5'd4);
        checks++; if (state_dbg !== 2'd1 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0) begin errors++; $display("FAIL lb_wrap_issue: state %0d rd %b addr %h need 1 1 0", state_dbg, bus.mem_read, bus.mem_address); end
        @(posedge clk); #1;
        checks++; if (bus.resp_data !== 32'hFFFFFF80 || bus.resp_rd !== 5'd4) begin errors++; $display("FAIL lb_wrap_data: data %h rd %0d need ffffff80 4", bus.resp_data, bus.resp_rd); end
        @(posedge clk); #1;
        drive_req(1'b1, 3'd1, 32'hFFF, 12'h000, 32'h0000BEEF, 5'd0);
        checks++; if (bus.exc_cause !== 4'd6 || bus.exc_addr !== 32'hFFF || bus.mem_write !== 1'b0) begin errors++; $display("FAIL sh_top_prio: cause %0d addr %h wr %b need 6 fff 0", bus.exc_cause, bus.exc_addr, bus.mem_write); end
        @(posedge clk); #1;
        drive_req(1'b0, 3'd2, 32'hFFFFFFFC, 12'h000, 32'd0, 5'd2);
        checks++; if (bus.exc_valid !== 1'b1 || bus.exc_cause !== 4'd5 || bus.exc_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL lw_wrap33: exc %b cause %0d addr %h need 1 5 fffffffc", bus.exc_valid, bus.exc_cause, bus.exc_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        drive_req(1'b0, 3'd3, 32'h101, 12'h000, 32'd0, 5'd6);
        checks++; if (bus.exc_valid !== 1'b1 || bus.exc_cause !== 4'd2 || bus.exc_addr !== 32'd0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL ld_f3_3: exc %b cause %0d addr %h rd %b need 1 2 0 0", bus.exc_valid, bus.exc_cause, bus.exc_addr, bus.mem_read); end
        @(posedge clk); #1;
        drive_req(1'b1, 3'd4, 32'h100, 12'h000, 32'h1, 5'd0);
        checks++; if (state_dbg !== 2'd2 || bus.exc_cause !== 4'd2 || bus.exc_addr !== 32'd0) begin errors++; $display("FAIL st_f3_4: state %0d cause %0d addr %h need 2 2 0", state_dbg, bus.exc_cause, bus.exc_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int wc0;
        int bad;
        wc0 = write_count;
        bad = 0;
        bus.resp_ready = 1'b0;
        drive_req(1'b0, 3'd2, 32'h100, 12'h004, 32'd0, 5'd7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            // a competing store is presented and must not be taken
            bus.req_is_store = 1'b1; bus.req_funct3 = 3'd0; bus.req_base = 32'h300;
            bus.req_offset = 12'h0; bus.req_wdata = 32'hFF; bus.req_valid = 1'b1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hDEADBEEF || bus.resp_rd !== 5'd7 ||
                bus.req_ready !== 1'b0 || state_dbg !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold_%0d: rv %b data %h rd %0d rdy %b state %0d need 1 deadbeef 7 0 2",
                         i, bus.resp_valid, bus.resp_data, bus.resp_rd, bus.req_ready, state_dbg);
            end
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (state_dbg !== 2'd0 || bus.resp_valid !== 1'b0 || write_count !== wc0) begin errors++; $display("FAIL bp_release: state %0d rv %b writes %0d need 0 0 %0d", state_dbg, bus.resp_valid, write_count, wc0); end
        bad = bad;
    endtask

    task automatic test_reset_mid();
        int wc0;
        mem[12'h200] = 8'h55;
        wc0 = write_count;
        drive_req(1'b1, 3'd0, 32'h200, 12'h000, 32'hAB, 5'd0);
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rst_issue_pre: wr %b need 1", bus.mem_write); end
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_issue_gate: wr %b need 0", bus.mem_write); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (state_dbg !== 2'd0 || mem[12'h200] !== 8'h55 || write_count !== wc0) begin errors++; $display("FAIL rst_issue_after: state %0d mem %h writes %0d need 0 55 %0d", state_dbg, mem[12'h200], write_count, wc0); end
        // reset while a response is waiting drops it
        bus.resp_ready = 1'b0;
        drive_req(1'b0, 3'd3, 32'h0, 12'h000, 32'd0, 5'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.exc_valid !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL rst_resp_drop: rv %b exc %b state %0d need 0 0 0", bus.resp_valid, bus.exc_valid, state_dbg); end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3, a4;
        bus.resp_ready = 1'b1;
        drive_req(1'b0, 3'd2, 32'h100, 12'h004, 32'd0, 5'd1);
        a1 = accept_cyc;
        drive_req(1'b0, 3'd2, 32'h100, 12'h004, 32'd0, 5'd2);
        a2 = accept_cyc;
        drive_req(1'b1, 3'd2, 32'h100, 12'h001, 32'd0, 5'd0);
        a3 = accept_cyc;
        drive_req(1'b1, 3'd2, 32'h100, 12'h001, 32'd0, 5'd0);
        a4 = accept_cyc;
        checks++; if (a2 - a1 !== 3) begin errors++; $display("FAIL b2b_legal_gap: got %0d need 3", a2 - a1); end
        checks++; if (a3 - a2 !== 3) begin errors++; $display("FAIL b2b_legal_to_trap_gap: got %0d need 3", a3 - a2); end
        checks++; if (a4 - a3 !== 2) begin errors++; $display("FAIL b2b_trap_gap: got %0d need 2", a4 - a3); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        write_count = 0;
        accept_cyc = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_base = 32'd0;
        bus.req_offset = 12'd0;
        bus.req_wdata = 32'd0;
        bus.req_rd = 5'd0;
        bus.resp_ready = 1'b1;

        test_reset();
        test_load_word();
        test_store_byte();
        test_misaligned();
        test_range();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
